// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Purpose:
//   Definitions shared by the asynchronous FIFO environment and the read-side
//   packetizer: the packetizer FSM state encoding, the default FIFO word
//   width, and the width of the delivered-packet counter.
//
// Contents:
//   DATA_WIDTH_DEF - default word width used by the FIFO and its consumers
//   PKT_CNT_W      - width of the delivered-packet counter (wraps modulo 2^16)
//   pkt_state_e    - packetizer FSM states (IDLE, BURST, GAP)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PKT_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } pkt_state_e;

endpackage : fifo_pkg

// File: rtl/skid_buffer_2.sv
// -----------------------------------------------------------------------------
// skid_buffer_2
//
// Purpose:
//   Two-entry, in-order valid/ready buffer with registered outputs. The output
//   side is driven straight from the head register, so o_data is stable for as
//   long as o_valid=1 and i_ready=0. A push and a pop may happen in the same
//   cycle. A push is only taken while o_in_ready=1 (fewer than two entries).
//
// Ports:
//   i_clk      - clock
//   i_rst      - synchronous reset, active-high; empties the buffer
//   i_valid    - upstream word present (taken only when o_in_ready=1)
//   o_in_ready - buffer has room for one more word
//   i_data     - upstream payload
//   o_valid    - head entry valid (buffer not empty)
//   i_ready    - downstream accepts the head entry this cycle
//   o_data     - head entry payload
//   o_count    - number of occupied entries (0..2)
// -----------------------------------------------------------------------------
module skid_buffer_2 #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_valid && (r_count != 2'd2);
    assign w_pop  = (r_count != 2'd0) && i_ready;

    // NOTE: every register in an always_ff is assigned with <= so all of them
    // update together from pre-edge values; a blocking = here would let later
    // statements see half-updated state and can differ between sim and synth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the two entries are flop-based storage, not a RAM, and the
            // head drives the output port directly, so they are cleared here to
            // give a defined all-zero output after reset.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({w_push, w_pop})
                        2'b11: r_head <= i_data;   // head leaves, new word replaces it
                        2'b10: begin
                            r_tail  <= i_data;
                            r_count <= 2'd2;
                        end
                        2'b01: r_count <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // Full: no push can be taken, only the head can leave.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    assign o_in_ready = (r_count != 2'd2);
    assign o_valid    = (r_count != 2'd0);
    assign o_data     = r_head;
    assign o_count    = r_count;

endmodule : skid_buffer_2

// File: rtl/fifo_read_packetizer.sv
// -----------------------------------------------------------------------------
// fifo_read_packetizer
//
// Purpose:
//   Drains the read port of a first-word-fall-through FIFO and re-emits the
//   words as a valid/ready stream framed into packets of PKT_LEN words, the
//   last word flagged with Out_last. GAP_CYCLES pop-free cycles are inserted
//   between packets. Output goes through a 2-entry skid buffer so downstream
//   backpressure never drops or duplicates a word.
//
// Parameters:
//   Data_width - word width, must match the FIFO
//   PKT_LEN    - words per packet (2..256)
//   GAP_CYCLES - idle cycles between packets; 0 gives back-to-back packets
//   CNT_W      - width of the in-packet word index
//
// Ports:
//   Rclk      - read-domain clock (FIFO read clock)
//   Rrst      - synchronous reset, active-high
//   Enable    - allows new packets to start
//   Rempty    - FIFO empty flag
//   Rdata     - FIFO head word, valid whenever Rempty=0
//   Rinc      - FIFO pop strobe (combinational)
//   Out_valid - stream word valid
//   Out_ready - downstream accept
//   Out_data  - stream word
//   Out_last  - final word of a packet
//   Busy      - FSM not idle or words still buffered
//   Pkt_count - packets fully delivered, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_read_packetizer
    import fifo_pkg::*;
#(
    parameter int Data_width = DATA_WIDTH_DEF,
    parameter int PKT_LEN    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = $clog2(PKT_LEN)
) (
    input  logic                  Rclk,
    input  logic                  Rrst,
    input  logic                  Enable,
    input  logic                  Rempty,
    input  logic [Data_width-1:0] Rdata,
    output logic                  Rinc,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [Data_width-1:0] Out_data,
    output logic                  Out_last,
    output logic                  Busy,
    output logic [PKT_CNT_W-1:0]  Pkt_count
);

    // Gap counter runs 0..GAP_CYCLES-1; keep at least one bit so the design
    // still elaborates when the gap is disabled.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    pkt_state_e            r_state;
    pkt_state_e            w_next_state;
    logic [CNT_W-1:0]      r_word_idx;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [PKT_CNT_W-1:0]  r_pkt_count;

    logic                  w_pop;
    logic                  w_word_last;
    logic                  w_buf_in_ready;
    logic [1:0]            w_buf_count;
    logic [Data_width:0]   w_buf_in;
    logic [Data_width:0]   w_buf_out;
    logic                  w_out_valid;
    logic                  w_deliver_last;

    assign w_word_last = (r_word_idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // Next-state and pop strobe
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: both outputs of this block get a value before any branch, so
        // every path assigns them and no latch is inferred.
        w_next_state = r_state;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                if (Enable) begin
                    w_next_state = BURST;
                end
            end

            BURST: begin
                if ((r_word_idx == '0) && !Enable) begin
                    // Between packets with Enable withdrawn: nothing has been
                    // popped for the next packet yet, so stop here rather than
                    // start one. Mid-packet, Enable is ignored until Last.
                    w_next_state = IDLE;
                end else begin
                    // Never pop an empty FIFO, and only pop into free buffer space.
                    w_pop = !Rempty && w_buf_in_ready;
                    if (w_pop && w_word_last) begin
                        if (GAP_CYCLES > 0) begin
                            w_next_state = GAP;
                        end else if (!Enable) begin
                            w_next_state = IDLE;
                        end
                    end
                end
            end

            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = Enable ? BURST : IDLE;
                end
            end

            default: w_next_state = IDLE;
        endcase

        // The strobe is combinational, so gate it directly while in reset.
        if (Rrst) begin
            w_pop = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State, word index, gap counter and delivered-packet counter
    // -------------------------------------------------------------------------
    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            r_state     <= IDLE;
            r_word_idx  <= '0;
            r_gap_cnt   <= '0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_pop) begin
                r_word_idx <= w_word_last ? '0 : r_word_idx + 1'b1;
            end

            // Counts the cycles already spent in GAP; cleared on every other
            // cycle so each gap starts from zero.
            if ((r_state == GAP) && (w_next_state == GAP)) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end

            if (w_deliver_last) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output skid buffer: payload is {data, last}
    // -------------------------------------------------------------------------
    assign w_buf_in = {Rdata, w_word_last};

    skid_buffer_2 #(
        .W (Data_width + 1)
    ) u_skid (
        .i_clk      (Rclk),
        .i_rst      (Rrst),
        .i_valid    (w_pop),
        .o_in_ready (w_buf_in_ready),
        .i_data     (w_buf_in),
        .o_valid    (w_out_valid),
        .i_ready    (Out_ready),
        .o_data     (w_buf_out),
        .o_count    (w_buf_count)
    );

    assign w_deliver_last = w_out_valid && Out_ready && w_buf_out[0];

    assign Rinc      = w_pop;
    assign Out_valid = w_out_valid;
    assign Out_data  = w_buf_out[Data_width:1];
    assign Out_last  = w_buf_out[0];
    assign Busy      = (r_state != IDLE) || (w_buf_count != 2'd0);
    assign Pkt_count = r_pkt_count;

endmodule : fifo_read_packetizer

// File: tb/tb_fifo_read_packetizer.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_packetizer
//
// Directed bench for fifo_read_packetizer (Data_width=8, PKT_LEN=4,
// GAP_CYCLES=2). A small first-word-fall-through FIFO model feeds the read
// port; a monitor logs every accepted output word with its cycle number.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_read_packetizer;

    logic        Rclk = 1'b0;
    logic        Rrst;
    logic        Enable;
    logic        Rempty;
    logic [7:0]  Rdata;
    logic        Rinc;
    logic        Out_valid;
    logic        Out_ready;
    logic [7:0]  Out_data;
    logic        Out_last;
    logic        Busy;
    logic [15:0] Pkt_count;

    int errors = 0;
    int checks = 0;

    always #5 Rclk = ~Rclk;

    fifo_read_packetizer #(
        .Data_width (8),
        .PKT_LEN    (4),
        .GAP_CYCLES (2)
    ) dut (
        .Rclk      (Rclk),
        .Rrst      (Rrst),
        .Enable    (Enable),
        .Rempty    (Rempty),
        .Rdata     (Rdata),
        .Rinc      (Rinc),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
        .Out_last  (Out_last),
        .Busy      (Busy),
        .Pkt_count (Pkt_count)
    );

    // FIFO model: writes from the stimulus process, pops on Rinc at the edge.
    logic [7:0] fifo_mem [0:255];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int rinc_viol = 0;

    assign Rempty = (wr_cnt == rd_cnt);
    assign Rdata  = fifo_mem[rd_cnt[7:0]];

    always @(posedge Rclk) begin
        if (Rinc === 1'b1) begin
            if (Rempty) rinc_viol <= rinc_viol + 1;
            else        rd_cnt    <= rd_cnt + 1;
        end
    end

    // Output monitor.
    logic [7:0] log_data [0:63];
    logic       log_last [0:63];
    int         log_cyc  [0:63];
    int         n_out = 0;
    int         cyc   = 0;

    always @(posedge Rclk) begin
        cyc <= cyc + 1;
        if (Rrst === 1'b0 && Out_valid === 1'b1 && Out_ready === 1'b1) begin
            log_data[n_out[5:0]] <= Out_data;
            log_last[n_out[5:0]] <= Out_last;
            log_cyc[n_out[5:0]]  <= cyc;
            n_out                <= n_out + 1;
        end
    end

    task automatic fifo_write(input logic [7:0] v);
        fifo_mem[wr_cnt[7:0]] = v;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic wait_out(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Rclk);
            if (n_out >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_pkts(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Rclk);
            if (int'(Pkt_count) >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Rclk);
            if (Busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        fifo_write(8'hA1);
        fifo_write(8'hA2);
        Rrst   = 1'b1;
        Enable = 1'b1;
        repeat (2) @(negedge Rclk);
        checks++; if (Rinc !== 1'b0)      begin errors++; $display("FAIL reset_rinc: got %b want 0", Rinc); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", Out_valid); end
        checks++; if (Out_data !== 8'd0)  begin errors++; $display("FAIL reset_data: got %0d want 0", Out_data); end
        checks++; if (Out_last !== 1'b0)  begin errors++; $display("FAIL reset_last: got %b want 0", Out_last); end
        checks++; if (Pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", Pkt_count); end
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (rd_cnt !== 0)       begin errors++; $display("FAIL reset_no_pop: got %0d pops want 0", rd_cnt); end
        Enable = 1'b0;
        wr_cnt = rd_cnt;            // discard the reset-test words
        Rrst   = 1'b0;
        @(negedge Rclk);
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL post_reset_busy: got %b want 0", Busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        int base;
        bit ok;
        base = n_out;
        for (int v = 11; v <= 18; v++) fifo_write(8'(v));
        Out_ready = 1'b1;
        Enable    = 1'b1;
        wait_pkts(2, 40, ok);
        Enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got Pkt_count=%0d want 2", Pkt_count); end
        checks++; if (n_out - base !== 8) begin errors++; $display("FAIL b2b_count: got %0d words want 8", n_out - base); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_data[base+i] !== 8'(11 + i) || log_last[base+i] !== ((i == 3) || (i == 7)))
                begin errors++; $display("FAIL b2b_word%0d: got %0d/last=%b want %0d/last=%b", i, log_data[base+i], log_last[base+i], 11 + i, (i == 3) || (i == 7)); end
        end
        checks++; if (log_cyc[base+3] - log_cyc[base] !== 3) begin errors++; $display("FAIL b2b_rate: got span %0d want 3", log_cyc[base+3] - log_cyc[base]); end
        checks++; if (log_cyc[base+4] - log_cyc[base+3] !== 3) begin errors++; $display("FAIL b2b_gap: got spacing %0d want 3", log_cyc[base+4] - log_cyc[base+3]); end
        checks++; if (Pkt_count !== 16'd2) begin errors++; $display("FAIL b2b_pkt_count: got %0d want 2", Pkt_count); end
        checks++; if (Rempty !== 1'b1)     begin errors++; $display("FAIL b2b_empty: got %b want 1", Rempty); end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: got Busy=%b want 0", Busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int base;
        int rinc_seen;
        int hold_bad;
        bit ok;
        base      = n_out;
        rinc_seen = 0;
        hold_bad  = 0;
        Out_ready = 1'b0;
        for (int v = 51; v <= 54; v++) fifo_write(8'(v));
        Enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Rclk);
            if (Rinc === 1'b1) rinc_seen++;
            if (Out_valid === 1'b1 && Out_data !== 8'd51) hold_bad++;
        end
        checks++; if (rinc_seen !== 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", rinc_seen); end
        checks++; if (hold_bad !== 0)  begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
        checks++; if (Out_valid !== 1'b1 || Out_data !== 8'd51 || Out_last !== 1'b0)
            begin errors++; $display("FAIL bp_head: got v=%b d=%0d l=%b want v=1 d=51 l=0", Out_valid, Out_data, Out_last); end
        checks++; if (wr_cnt - rd_cnt !== 2) begin errors++; $display("FAIL bp_fifo_level: got %0d want 2", wr_cnt - rd_cnt); end
        Out_ready = 1'b1;
        wait_out(base + 4, 30, ok);
        Enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d words want 4", n_out - base); end
        repeat (3) @(negedge Rclk);
        checks++; if (n_out - base !== 4) begin errors++; $display("FAIL bp_count: got %0d words want 4", n_out - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_data[base+i] !== 8'(51 + i) || log_last[base+i] !== (i == 3))
                begin errors++; $display("FAIL bp_word%0d: got %0d/last=%b want %0d/last=%b", i, log_data[base+i], log_last[base+i], 51 + i, i == 3); end
        end
        checks++; if (Pkt_count !== 16'd3) begin errors++; $display("FAIL bp_pkt_count: got %0d want 3", Pkt_count); end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_idle: got Busy=%b want 0", Busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_starvation();
        int base;
        bit ok;
        base      = n_out;
        Out_ready = 1'b1;
        fifo_write(8'd21);
        fifo_write(8'd22);
        Enable = 1'b1;
        repeat (10) @(negedge Rclk);
        checks++; if (n_out - base !== 2) begin errors++; $display("FAIL starve_partial: got %0d words want 2", n_out - base); end
        checks++; if (log_data[base] !== 8'd21 || log_data[base+1] !== 8'd22 || log_last[base] !== 1'b0 || log_last[base+1] !== 1'b0)
            begin errors++; $display("FAIL starve_first_words: got %0d,%0d last %b%b want 21,22 last 00", log_data[base], log_data[base+1], log_last[base], log_last[base+1]); end
        checks++; if (Busy !== 1'b1)       begin errors++; $display("FAIL starve_busy: got %b want 1", Busy); end
        checks++; if (Pkt_count !== 16'd3) begin errors++; $display("FAIL starve_no_early_last: got %0d want 3", Pkt_count); end
        fifo_write(8'd23);
        fifo_write(8'd24);
        wait_pkts(4, 20, ok);
        Enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL starve_timeout: got Pkt_count=%0d want 4", Pkt_count); end
        checks++; if (log_data[base+2] !== 8'd23 || log_last[base+2] !== 1'b0 || log_data[base+3] !== 8'd24 || log_last[base+3] !== 1'b1)
            begin errors++; $display("FAIL starve_tail: got %0d/%b,%0d/%b want 23/0,24/1", log_data[base+2], log_last[base+2], log_data[base+3], log_last[base+3]); end
        checks++; if (rinc_viol !== 0) begin errors++; $display("FAIL starve_rinc_on_empty: got %0d want 0", rinc_viol); end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL starve_idle: got Busy=%b want 0", Busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_enable_drop();
        int base;
        bit ok;
        base      = n_out;
        Out_ready = 1'b1;
        for (int v = 31; v <= 38; v++) fifo_write(8'(v));
        Enable = 1'b1;
        wait_out(base + 1, 20, ok);
        Enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL endrop_first_word: got %0d words want 1", n_out - base); end
        wait_pkts(5, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_complete: got Pkt_count=%0d want 5", Pkt_count); end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_idle: got Busy=%b want 0", Busy); end
        repeat (4) @(negedge Rclk);
        checks++; if (n_out - base !== 4) begin errors++; $display("FAIL endrop_count: got %0d words want 4", n_out - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_data[base+i] !== 8'(31 + i) || log_last[base+i] !== (i == 3))
                begin errors++; $display("FAIL endrop_word%0d: got %0d/last=%b want %0d/last=%b", i, log_data[base+i], log_last[base+i], 31 + i, i == 3); end
        end
        checks++; if (wr_cnt - rd_cnt !== 4 || Rdata !== 8'd35)
            begin errors++; $display("FAIL endrop_fifo_rest: got level %0d head %0d want level 4 head 35", wr_cnt - rd_cnt, Rdata); end
        wr_cnt = rd_cnt;            // discard the untouched remainder
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_packet();
        int base;
        int base2;
        bit ok;
        base      = n_out;
        Out_ready = 1'b1;
        for (int v = 41; v <= 48; v++) fifo_write(8'(v));
        Enable = 1'b1;
        wait_out(base + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_two_words: got %0d words want 2", n_out - base); end
        Rrst = 1'b1;
        #1;
        checks++; if (Rinc !== 1'b0) begin errors++; $display("FAIL rstmid_rinc: got %b want 0", Rinc); end
        @(negedge Rclk);
        checks++; if (Out_valid !== 1'b0 || Busy !== 1'b0 || Pkt_count !== 16'd0)
            begin errors++; $display("FAIL rstmid_cleared: got v=%b busy=%b pkts=%0d want 0,0,0", Out_valid, Busy, Pkt_count); end
        Rrst  = 1'b0;
        base2 = n_out;
        checks++; if (base2 - base !== 2 || log_data[base] !== 8'd41 || log_data[base+1] !== 8'd42)
            begin errors++; $display("FAIL rstmid_pre: got %0d words %0d,%0d want 2 words 41,42", base2 - base, log_data[base], log_data[base+1]); end
        wait_pkts(1, 20, ok);
        Enable = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: got Pkt_count=%0d want 1", Pkt_count); end
        checks++; if (n_out - base2 !== 4) begin errors++; $display("FAIL rstmid_count: got %0d words want 4", n_out - base2); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_data[base2+i] !== 8'(44 + i) || log_last[base2+i] !== (i == 3))
                begin errors++; $display("FAIL rstmid_word%0d: got %0d/last=%b want %0d/last=%b", i, log_data[base2+i], log_last[base2+i], 44 + i, i == 3); end
        end
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: got Busy=%b want 0", Busy); end
        checks++; if (wr_cnt - rd_cnt !== 1 || Rdata !== 8'd48)
            begin errors++; $display("FAIL rstmid_fifo_rest: got level %0d head %0d want level 1 head 48", wr_cnt - rd_cnt, Rdata); end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        Rrst      = 1'b1;
        Enable    = 1'b0;
        Out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_starvation();
        test_enable_drop();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_fifo_read_packetizer
